// File: rtl/huffman_packer.sv
`default_nettype none
// ============================================================================
//  Module   : huffman_packer
//  Purpose  : Latches a six-entry Huffman code table, replaces each incoming
//             symbol by its variable-length code and packs the codes MSB-first
//             into an output byte stream with pad bits and an end marker.
//  Revision : 1.0  initial release
// ============================================================================
module huffman_packer #(
    parameter logic PAD_BIT = 1'b0,
    parameter int   CNT_W   = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             code_valid,
    input  logic [7:0]       HC1,
    input  logic [7:0]       HC2,
    input  logic [7:0]       HC3,
    input  logic [7:0]       HC4,
    input  logic [7:0]       HC5,
    input  logic [7:0]       HC6,
    input  logic [7:0]       M1,
    input  logic [7:0]       M2,
    input  logic [7:0]       M3,
    input  logic [7:0]       M4,
    input  logic [7:0]       M5,
    input  logic [7:0]       M6,
    input  logic             sym_valid,
    input  logic [7:0]       sym_data,
    input  logic             sym_last,
    output logic             sym_ready,
    output logic             out_valid,
    output logic [7:0]       out_byte,
    output logic             out_last,
    input  logic             out_ready,
    output logic             done,
    output logic             sym_err,
    output logic [CNT_W-1:0] byte_count
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_FLUSH = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    localparam logic [CNT_W-1:0] C_BC_MAX = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] C_BC_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    // Code length is the number of ones in the (contiguous) mask.
    function automatic logic [3:0] popcnt8(input logic [7:0] v);
        logic [3:0] c;
        c = 4'd0;
        for (int b = 0; b < 8; b++) begin
            c = c + {3'b000, v[b]};
        end
        return c;
    endfunction

    state_t            state_q, state_d;
    logic [15:0]       acc_q, acc_d;
    logic [4:0]        cnt_q, cnt_d;
    logic              sym_err_q, sym_err_d;
    logic [CNT_W-1:0]  byte_count_q, byte_count_d;
    logic              done_q, done_d;

    logic [7:0]        hc_q  [1:6];
    logic [3:0]        len_q [1:6];
    logic [7:0]        w_hc_in [1:6];
    logic [7:0]        w_m_in  [1:6];

    logic              w_load;
    logic [2:0]        w_sym;
    logic [7:0]        w_hc;
    logic [3:0]        w_len;
    logic              w_sym_ok;
    logic [8:0]        w_mask9;
    logic [7:0]        w_code8;
    logic [15:0]       w_code16;
    logic [7:0]        w_byte;
    logic              w_unused;

    assign w_hc_in[1] = HC1;
    assign w_hc_in[2] = HC2;
    assign w_hc_in[3] = HC3;
    assign w_hc_in[4] = HC4;
    assign w_hc_in[5] = HC5;
    assign w_hc_in[6] = HC6;
    assign w_m_in[1]  = M1;
    assign w_m_in[2]  = M2;
    assign w_m_in[3]  = M3;
    assign w_m_in[4]  = M4;
    assign w_m_in[5]  = M5;
    assign w_m_in[6]  = M6;

    // Only the low three symbol bits select a table entry.
    assign w_unused = ^sym_data[7:3];
    assign w_sym    = sym_data[2:0];

    // A new table is only taken between images, never while packing.
    assign w_load = code_valid && ((state_q == S_IDLE) || (state_q == S_DONE));

    // Code table storage: code bits and 4-bit length per entry.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int k = 1; k <= 6; k++) begin
                hc_q[k]  <= 8'h00;
                len_q[k] <= 4'd0;
            end
        end else if (w_load) begin
            for (int k = 1; k <= 6; k++) begin
                hc_q[k]  <= w_hc_in[k];
                len_q[k] <= popcnt8(w_m_in[k]);
            end
        end
    end

    // Table lookup and alignment of the code at the accumulator fill point.
    always_comb begin
        w_hc  = 8'h00;
        w_len = 4'd0;
        for (int k = 1; k <= 6; k++) begin
            if (w_sym == 3'(k)) begin
                w_hc  = hc_q[k];
                w_len = len_q[k];
            end
        end
        // Entries 0 and 7 do not exist; a zero length is equally unusable.
        w_sym_ok = (w_sym >= 3'd1) && (w_sym <= 3'd6) && (w_len != 4'd0);
        w_mask9  = (9'd1 << w_len) - 9'd1;
        w_code8  = w_hc & w_mask9[7:0];
        // Left-justify the code in 16 bits, then move it below the valid bits.
        w_code16 = ({8'h00, w_code8} << (5'd16 - {1'b0, w_len})) >> cnt_q;
    end

    // Output byte: top of the accumulator, with unfilled bits padded in FLUSH.
    always_comb begin
        w_byte = acc_q[15:8];
        if (state_q == S_FLUSH) begin
            for (int b = 0; b < 8; b++) begin
                if (5'(7 - b) >= cnt_q) begin
                    w_byte[b] = PAD_BIT;
                end
            end
        end
    end

    assign out_byte   = w_byte;
    assign done       = done_q;
    assign sym_err    = sym_err_q;
    assign byte_count = byte_count_q;

    // State, accumulator and counter registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= S_IDLE;
            acc_q        <= 16'h0000;
            cnt_q        <= 5'd0;
            sym_err_q    <= 1'b0;
            byte_count_q <= '0;
            done_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            acc_q        <= acc_d;
            cnt_q        <= cnt_d;
            sym_err_q    <= sym_err_d;
            byte_count_q <= byte_count_d;
            done_q       <= done_d;
        end
    end

    // Next-state logic: table load, symbol append, byte pop and flush exit.
    always_comb begin
        state_d      = state_q;
        acc_d        = acc_q;
        cnt_d        = cnt_q;
        sym_err_d    = sym_err_q;
        byte_count_d = byte_count_q;
        sym_ready    = 1'b0;
        out_valid    = 1'b0;
        out_last     = 1'b0;

        case (state_q)
            S_IDLE, S_DONE: begin
                if (code_valid) begin
                    state_d      = S_RUN;
                    acc_d        = 16'h0000;
                    cnt_d        = 5'd0;
                    sym_err_d    = 1'b0;
                    byte_count_d = '0;
                end
            end
            S_RUN: begin
                // Accept only while a full code still fits: cnt <= 7 + 8.
                sym_ready = (cnt_q < 5'd8);
                out_valid = (cnt_q >= 5'd8);
                if (sym_valid && sym_ready) begin
                    if (w_sym_ok) begin
                        acc_d = acc_q | w_code16;
                        cnt_d = cnt_q + {1'b0, w_len};
                    end else begin
                        sym_err_d = 1'b1;
                    end
                    if (sym_last) begin
                        state_d = S_FLUSH;
                    end
                end
            end
            S_FLUSH: begin
                if (cnt_q == 5'd0) begin
                    // Nothing left to emit: finish without a byte.
                    state_d = S_DONE;
                end else begin
                    out_valid = 1'b1;
                    out_last  = (cnt_q <= 5'd8);
                    if (out_ready && out_last) begin
                        state_d = S_DONE;
                    end
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        if (out_valid && out_ready) begin
            acc_d = acc_q << 8;
            cnt_d = (cnt_q >= 5'd8) ? (cnt_q - 5'd8) : 5'd0;
            if (byte_count_q != C_BC_MAX) begin
                byte_count_d = byte_count_q + C_BC_ONE;
            end
        end

        done_d = (state_d == S_DONE) && (state_q != S_DONE);
    end

endmodule
`default_nettype wire

// File: tb/tb_huffman_packer.sv
`default_nettype none
// ============================================================================
//  Module   : tb_huffman_packer
//  Purpose  : Randomized self-checking bench for huffman_packer against a
//             bit-queue reference model of the packed output stream.
//  Revision : 1.0  initial release
// ============================================================================
module tb_huffman_packer;

    localparam logic PAD_BIT = 1'b0;
    localparam int   CNT_W   = 16;

    logic             clk = 1'b0;
    logic             reset = 1'b0;
    logic             code_valid = 1'b0;
    logic [7:0]       hc [1:6];
    logic [7:0]       m  [1:6];
    logic             sym_valid = 1'b0;
    logic [7:0]       sym_data = 8'h00;
    logic             sym_last = 1'b0;
    logic             sym_ready;
    logic             out_valid;
    logic [7:0]       out_byte;
    logic             out_last;
    logic             out_ready = 1'b0;
    logic             done;
    logic             sym_err;
    logic [CNT_W-1:0] byte_count;

    int total = 0;
    int bad   = 0;

    int   stim[$];
    logic [7:0] got_b[$];
    logic       got_l[$];
    logic [7:0] exp_b[$];
    logic       exp_err;

    huffman_packer #(.PAD_BIT(PAD_BIT), .CNT_W(CNT_W)) dut (
        .clk(clk), .reset(reset), .code_valid(code_valid),
        .HC1(hc[1]), .HC2(hc[2]), .HC3(hc[3]), .HC4(hc[4]), .HC5(hc[5]), .HC6(hc[6]),
        .M1(m[1]), .M2(m[2]), .M3(m[3]), .M4(m[4]), .M5(m[5]), .M6(m[6]),
        .sym_valid(sym_valid), .sym_data(sym_data), .sym_last(sym_last),
        .sym_ready(sym_ready), .out_valid(out_valid), .out_byte(out_byte),
        .out_last(out_last), .out_ready(out_ready), .done(done),
        .sym_err(sym_err), .byte_count(byte_count)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference: concatenate code bits, cut into bytes, pad the tail.
    task automatic build_expect();
        bit bits[$];
        int s, len, nb;
        logic [7:0] b;
        exp_b.delete();
        exp_err = 1'b0;
        foreach (stim[i]) begin
            s = stim[i] & 7;
            len = (s >= 1 && s <= 6) ? $countones(m[s]) : 0;
            if (len == 0) begin
                exp_err = 1'b1;
            end else begin
                for (int j = len - 1; j >= 0; j--) bits.push_back(hc[s][j]);
            end
        end
        nb = (bits.size() + 7) / 8;
        for (int j = 0; j < nb; j++) begin
            for (int k = 0; k < 8; k++) begin
                b[7-k] = (j*8 + k < bits.size()) ? bits[j*8 + k] : PAD_BIT;
            end
            exp_b.push_back(b);
        end
    endtask

    task automatic set_table_a();
        hc[1] = 8'h00; m[1] = 8'h01;
        hc[2] = 8'h02; m[2] = 8'h03;
        hc[3] = 8'h06; m[3] = 8'h07;
        hc[4] = 8'h0E; m[4] = 8'h0F;
        hc[5] = 8'h1E; m[5] = 8'h1F;
        hc[6] = 8'h1F; m[6] = 8'h1F;
    endtask

    task automatic set_table_rand();
        int len;
        for (int k = 1; k <= 6; k++) begin
            len = $urandom_range(0, 8);
            m[k]  = 8'((9'd1 << len) - 9'd1);
            hc[k] = 8'($urandom);
        end
    endtask

    task automatic load_table();
        @(negedge clk);
        code_valid = 1'b1;
        @(negedge clk);
        code_valid = 1'b0;
    endtask

    // mode 0: always ready, 1: random gaps/backpressure, 2: first byte stalled 5 cycles
    task automatic run_stream(input int mode, input string name);
        int idx = 0;
        int cyc = 0;
        int stall_left = (mode == 2) ? 5 : 0;
        bit seen_done = 0;
        bit held = 0;
        logic [7:0] held_b = 8'h00;
        logic held_l = 1'b0;
        int n;
        build_expect();
        got_b.delete();
        got_l.delete();
        while (!seen_done && cyc < 3000) begin
            @(negedge clk);
            if (idx < stim.size()) begin
                sym_valid = (mode == 1) ? ($urandom_range(0, 3) != 0) : 1'b1;
                sym_data  = 8'(stim[idx]);
                sym_last  = (idx == stim.size() - 1);
            end else begin
                sym_valid = 1'b0;
                sym_last  = 1'b0;
                sym_data  = 8'($urandom);
            end
            if (mode == 1)      out_ready = ($urandom_range(0, 2) != 0);
            else if (mode == 2) out_ready = !(stall_left > 0 && out_valid);
            else                out_ready = 1'b1;
            #1;
            if (done) seen_done = 1;
            if (held) begin
                check({name, " hold_valid"}, out_valid, 1);
                check({name, " hold_byte"}, out_byte, held_b);
                check({name, " hold_last"}, out_last, held_l);
            end
            if (out_valid) check({name, " excl"}, sym_ready, 0);
            if (sym_valid && sym_ready) idx++;
            held = 0;
            if (out_valid && out_ready) begin
                got_b.push_back(out_byte);
                got_l.push_back(out_last);
            end else if (out_valid) begin
                held = 1; held_b = out_byte; held_l = out_last;
                if (stall_left > 0) stall_left--;
            end
            cyc++;
        end
        sym_valid = 1'b0;
        sym_last  = 1'b0;
        check({name, " done_seen"}, seen_done, 1);
        check({name, " consumed"}, idx, stim.size());
        check({name, " nbytes"}, got_b.size(), exp_b.size());
        n = (got_b.size() < exp_b.size()) ? got_b.size() : exp_b.size();
        for (int i = 0; i < n; i++) begin
            check({name, " byte"}, got_b[i], exp_b[i]);
            check({name, " last"}, got_l[i], (i == exp_b.size() - 1));
        end
        check({name, " sym_err"}, sym_err, exp_err);
        check({name, " byte_count"}, byte_count, exp_b.size());
        @(negedge clk);
        #1;
        check({name, " done_pulse"}, done, 0);
    endtask

    task automatic check_all_zero(input string name);
        check({name, " sym_ready"}, sym_ready, 0);
        check({name, " out_valid"}, out_valid, 0);
        check({name, " out_byte"}, out_byte, 0);
        check({name, " out_last"}, out_last, 0);
        check({name, " done"}, done, 0);
        check({name, " sym_err"}, sym_err, 0);
        check({name, " byte_count"}, byte_count, 0);
    endtask

    initial begin
        int r, len, s;
        set_table_a();
        #2 reset = 1'b1;
        #1 check_all_zero("rst");
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        #1 check_all_zero("idle");

        load_table();
        stim = '{1, 2, 3};
        run_stream(0, "t123");
        if (got_b.size() == 1) check("t123 const", got_b[0], 8'h58);

        load_table();
        stim = '{6, 6};
        run_stream(0, "t66");
        if (got_b.size() == 2) begin
            check("t66 b0", got_b[0], 8'hFF);
            check("t66 b1", got_b[1], 8'hC0);
        end

        load_table();
        stim = '{4, 4};
        run_stream(0, "t44");
        if (got_b.size() == 1) check("t44 const", got_b[0], 8'hEE);

        load_table();
        stim = '{6, 6, 5, 3, 2};
        run_stream(2, "stall");

        load_table();
        stim = '{0, 7, 1};
        run_stream(0, "inval");
        if (got_b.size() == 1) check("inval const", got_b[0], 8'h00);

        load_table();
        #1;
        check("reload sym_err", sym_err, 0);
        check("reload byte_count", byte_count, 0);
        stim = '{8'hF8 | 7};
        run_stream(0, "empty");

        for (int it = 0; it < 25; it++) begin
            set_table_rand();
            load_table();
            stim.delete();
            len = $urandom_range(1, 40);
            for (int i = 0; i < len; i++) begin
                r = $urandom_range(0, 13);
                s = (r < 12) ? (r % 6) + 1 : ((r == 12) ? 0 : 7);
                stim.push_back(($urandom_range(0, 31) << 3) | s);
            end
            run_stream(it % 2, "rand");
        end

        // Reset in the middle of an image with five bits buffered.
        set_table_a();
        load_table();
        sym_valid = 1'b1; sym_last = 1'b0; sym_data = 8'd4; out_ready = 1'b1;
        @(negedge clk);
        sym_data = 8'd1;
        @(negedge clk);
        sym_valid = 1'b0;
        #2 reset = 1'b1;
        #1 check_all_zero("midrst");
        @(negedge clk);
        reset = 1'b0;
        sym_valid = 1'b1; sym_data = 8'd6; sym_last = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            #1;
            check("midrst no_accept", sym_ready, 0);
            check("midrst no_out", out_valid, 0);
        end
        sym_valid = 1'b0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/huffman_packer.md
Name: huffman_packer

Overview:
Downstream consumer of the Huffman code-table stage. It latches the six codes (HC1..HC6) and masks (M1..M6) on code_valid, then accepts the gray symbol stream a second time. Each symbol is replaced by its variable-length code. Codes are packed MSB-first into bytes for the output byte stream, with zero padding and an end marker on the final byte.

Parameters:
PAD_BIT, 1'b0, value used to pad the final partial byte.
CNT_W, 16, width of the emitted-byte counter.

Ports:
clk  in  1  clock
reset  in  1  asynchronous, active-high reset
code_valid  in  1  one-cycle pulse: HC1..HC6 and M1..M6 are valid
HC1..HC6  in  8 each  code bits, right-aligned
M1..M6  in  8 each  right-aligned contiguous ones mask; code length = popcount(Mi)
sym_valid  in  1  symbol present
sym_data  in  8  symbol; only [2:0] used, values 1..6 map to table entries 1..6
sym_last  in  1  qualifies the final symbol of the image
sym_ready  out  1  block can accept a symbol this cycle
out_valid  out  1  out_byte valid
out_byte  out  8  packed code byte; first code bit in bit 7
out_last  out  1  final byte of the stream
out_ready  in  1  downstream accepts out_byte
done  out  1  one-cycle pulse on entry to DONE
sym_err  out  1  sticky invalid-symbol flag
byte_count  out  CNT_W  bytes emitted, saturating

Behaviour:
- Reset: asynchronous and active-high; clock is clk. Reset clears the table to all zero, acc = 0, cnt = 0 and state = IDLE. All outputs are 0 after reset. Reset mid-stream discards everything, with no partial flush.
- Table load: in IDLE or DONE, code_valid latches all 12 inputs. The length is stored as a 4-bit popcount of Mi, range 0..8. The load also clears sym_err and byte_count, and the next state is RUN. code_valid in RUN or FLUSH is ignored.
- Bit accumulator: acc[15:0] is left-justified, with valid bits in acc[15:16-cnt]. cnt is 5 bits, range 0..15.
- out_byte = acc[15:8], driven combinationally from registers.
- States:
  - IDLE: sym_ready = 0, out_valid = 0. Waits for code_valid.
  - RUN: sym_ready = (cnt < 8); out_valid = (cnt >= 8), out_last = 0. The two are mutually exclusive.
  - FLUSH: sym_ready = 0; out_valid = (cnt > 0), out_last = (cnt <= 8).
  - DONE: all handshakes low. Holds until code_valid or reset.
- Symbol accept (sym_valid & sym_ready):
  - Let s = sym_data[2:0] and len = table length[s].
  - Valid when s is 1..6 and len is non-zero: the code bits HC[s][len-1:0] are appended MSB-first at bit position 15-cnt, and cnt += len.
  - Otherwise the symbol is consumed, no bits are appended, and sym_err is set.
  - If sym_last is set on an accepted symbol, the state becomes FLUSH on the next cycle.
- Byte pop (out_valid & out_ready):
  - acc <<= 8; cnt = (cnt >= 8) ? cnt - 8 : 0.
  - byte_count increments, saturating at all ones.
  - In a partial FLUSH byte, the unused low bits show PAD_BIT. Bits below cnt are forced to PAD_BIT.
- FLUSH exit:
  - After the pop that carries out_last, the next state is DONE and done pulses.
  - If FLUSH is entered with cnt = 0 (last symbol was invalid and the accumulator was empty), go to DONE on the next cycle. No byte is emitted and done pulses.
- Latency: a symbol accepted in cycle t that brings cnt to 8 or more gives out_valid in cycle t+1.
- Backpressure: with out_ready low, out_byte, out_valid and out_last stay stable. sym_ready stays low while cnt >= 8, so acc never overflows (max cnt = 7 + 8 = 15).
- Length-0 table entries (mask 0) are treated as invalid symbols.

Test Plan:
- Table: 1="0"(M=01), 2="10"(M=03), 3="110"(07), 4="1110"(0F), 5="11110"(1F), 6="11111"(1F). Stream 1, 2, 3 with last on 3 -> one byte 0x58 with out_last=1, done pulse, byte_count=1.
- Same table, stream 6, 6 with last -> 0xFF (out_last=0) then 0xC0 (out_last=1); sym_ready low while cnt=10 until the first pop.
- Stream 4, 4 with last on second -> exactly 8 bits -> single byte 0xEE with out_last=1, no pad byte.
- Hold out_ready=0 for 5 cycles while cnt>=8 -> out_byte stable, sym_ready=0, no symbol lost; release -> bytes identical to the no-stall run.
- sym_data=0 then 7 then 1 with last -> sym_err=1, output byte 0x00 with out_last; next code_valid clears sym_err and byte_count.
- Assert reset during RUN with cnt=5 -> all outputs 0 immediately; sym_data without a new code_valid is never accepted (sym_ready=0).
